// File: rtl/multicycle_control_v2.sv
// Multicycle RV32I control FSM for the shared-memory multicycle datapath.
// Handles loads, stores, R-type, I-ALU, branch, JAL, JALR, LUI and AUIPC,
// with a memory ready handshake guarded by a wait-state timeout, an
// illegal-opcode trap and a per-instruction retire pulse.
//
// Ports:
//   clk          in   system clock
//   resetn       in   asynchronous active-low reset
//   opcode[6:0]  in   IR[6:0] of the instruction in flight
//   mem_ready    in   memory completes the current request this cycle
//   branch_taken in   datapath comparator result for the current funct3
//   state[3:0]   out  current state encoding
//   mem_req      out  memory request
//   mem_we       out  memory write qualifier
//   adr_src      out  memory address select: 0=PC, 1=alu_out
//   ir_write     out  latch IR and old_pc
//   pc_write     out  PC load
//   reg_write    out  register file write
//   alu_src_a    out  00 PC, 01 old_pc, 10 rs1
//   alu_src_b    out  00 rs2, 01 imm, 10 const 4
//   alu_op       out  00 add, 01 sub/compare, 10 R-decode, 11 I-decode
//   imm_src      out  000 I, 001 S, 010 B, 011 U, 100 J
//   result_src   out  00 alu_out, 01 mem data, 10 ALU result, 11 imm
//   retire       out  one-cycle pulse in the final state of an instruction
//   fault        out  sticky fault flag (set while parked in FAULT)
//   fault_cause  out  01 illegal opcode, 10 memory timeout, 00 none
module multicycle_control_v2 #(
  parameter int unsigned MEM_HANDSHAKE = 1,
  parameter int unsigned TIMEOUT       = 16,
  parameter int unsigned TRAP_ILLEGAL  = 1,
  parameter int unsigned TW            = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic [3:0] state,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_src,
  output logic [1:0] result_src,
  output logic       retire,
  output logic       fault,
  output logic [1:0] fault_cause
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_MEM_ADDR  = 4'd4,
    S_MEM_RD    = 4'd5,
    S_MEM_WR    = 4'd6,
    S_WB_MEM    = 4'd7,
    S_WB_ALU    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR      = 4'd11,
    S_LUI       = 4'd12,
    S_AUIPC     = 4'd13,
    S_JALR_LINK = 4'd14,
    S_FAULT     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // Counter value on the last stall cycle allowed before the timeout fires.
  localparam logic [TW-1:0] WAIT_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] wait_q, wait_d;
  logic [1:0]    cause_q, cause_d;
  logic          accept;
  logic          stall;
  logic          req;

  assign accept = (MEM_HANDSHAKE == 0) || mem_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    cause_d    = cause_q;
    stall      = 1'b0;
    req        = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    imm_src    = 3'b000;
    result_src = 2'b00;
    retire     = 1'b0;
    fault      = 1'b0;

    case (state_q)
      S_FETCH: begin
        req        = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (accept) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else begin
          stall = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = (opcode == OP_JAL) ? 3'b100 : 3'b010;
        case (opcode)
          OP_LOAD,
          OP_STORE: state_d = S_MEM_ADDR;
          OP_R:     state_d = S_EXEC_R;
          OP_I:     state_d = S_EXEC_I;
          OP_BR:    state_d = S_BRANCH;
          OP_JAL:   state_d = S_JAL;
          OP_JALR:  state_d = S_JALR;
          OP_LUI:   state_d = S_LUI;
          OP_AUIPC: state_d = S_AUIPC;
          default: begin
            if (TRAP_ILLEGAL != 0) begin
              state_d = S_FAULT;
              cause_d = 2'b01;
            end else begin
              state_d = S_FETCH;
              retire  = 1'b1;
            end
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b11;
        state_d   = S_WB_ALU;
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        // IR is held across the instruction, so opcode still tells load from store.
        if (opcode == OP_STORE) begin
          imm_src = 3'b001;
          state_d = S_MEM_WR;
        end else begin
          state_d = S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        req     = 1'b1;
        adr_src = 1'b1;
        if (accept) state_d = S_WB_MEM;
        else        stall   = 1'b1;
      end
      S_MEM_WR: begin
        req     = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        if (accept) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          stall = 1'b1;
        end
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        result_src = 2'b01;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = branch_taken;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_WB_ALU;
      end
      S_JALR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = 1'b1;
        state_d    = S_JALR_LINK;
      end
      S_JALR_LINK: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = S_WB_ALU;
      end
      S_LUI: begin
        imm_src    = 3'b011;
        result_src = 2'b11;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 3'b011;
        state_d   = S_WB_ALU;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_d = S_FAULT;
        cause_d = 2'b00;
      end
    endcase

    // Accept has already been folded into stall, so a ready on the last
    // allowed cycle leaves the wait state instead of faulting.
    if (stall) begin
      if ((TIMEOUT != 0) && (wait_q == WAIT_LAST)) begin
        state_d = S_FAULT;
        cause_d = 2'b10;
      end else begin
        wait_d = wait_q + TW'(1);
      end
    end
    if (state_d != state_q) wait_d = '0;
  end

  // Gated by resetn so a reset arriving mid-wait withdraws the request at once.
  assign mem_req     = req & resetn;
  assign state       = state_q;
  assign fault_cause = cause_q;

endmodule

// File: tb/tb_multicycle_control_v2.sv
module tb_multicycle_control_v2;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  // Instances: 0 default, 1 TIMEOUT=4, 2 TRAP_ILLEGAL=0, 3 MEM_HANDSHAKE=0
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       mem_ready = 1'b0;
  logic       branch_taken = 1'b0;
  logic [6:0] opcode = OP_LW;
  logic [24:0] obs [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic [3:0] st;
    logic       req, we, adr, irw, pcw, rw, ret, flt;
    logic [1:0] a, b, aop, rs, fc;
    logic [2:0] imm;
    multicycle_control_v2 #(
      .MEM_HANDSHAKE((g == 3) ? 0 : 1),
      .TIMEOUT((g == 1) ? 4 : 16),
      .TRAP_ILLEGAL((g == 2) ? 0 : 1),
      .TW(8)
    ) dut (
      .clk(clk), .resetn(resetn), .opcode(opcode), .mem_ready(mem_ready),
      .branch_taken(branch_taken), .state(st), .mem_req(req), .mem_we(we),
      .adr_src(adr), .ir_write(irw), .pc_write(pcw), .reg_write(rw),
      .alu_src_a(a), .alu_src_b(b), .alu_op(aop), .imm_src(imm),
      .result_src(rs), .retire(ret), .fault(flt), .fault_cause(fc)
    );
    assign obs[g] = {st, req, we, adr, irw, pcw, rw, a, b, aop, imm, rs, ret, flt, fc};
  end

  typedef struct {
    int unsigned inst;
    logic [3:0]  st;
    logic [6:0]  op;
    logic        mr;
    logic        bt;
    logic [1:0]  cause;
  } ent_t;

  ent_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic cfg_hs(input int unsigned i);
    return i != 3;
  endfunction

  function automatic logic cfg_trap(input int unsigned i);
    return i != 2;
  endfunction

  function automatic logic legal(input logic [6:0] op);
    return op == OP_LW || op == OP_SW || op == OP_R || op == OP_I || op == OP_BR ||
           op == OP_JAL || op == OP_JALR || op == OP_LUI || op == OP_AUIPC;
  endfunction

  // Expected output vector for one cycle, straight from the state table.
  function automatic logic [24:0] exp_vec(input logic [3:0] st, input logic [6:0] op,
                                          input logic bt, input logic acc,
                                          input logic [1:0] cause, input logic trap);
    logic       req, we, adr, irw, pcw, rw, ret, flt;
    logic [1:0] a, b, aop, rs, fc;
    logic [2:0] imm;
    {req, we, adr, irw, pcw, rw, ret, flt} = '0;
    {a, b, aop, rs, fc} = '0;
    imm = '0;
    case (st)
      4'd0:  begin req = 1; b = 2'b10; rs = 2'b10; irw = acc; pcw = acc; end
      4'd1:  begin a = 2'b01; b = 2'b01; imm = (op == OP_JAL) ? 3'b100 : 3'b010;
                   ret = !trap && !legal(op); end
      4'd2:  begin a = 2'b10; aop = 2'b10; end
      4'd3:  begin a = 2'b10; b = 2'b01; aop = 2'b11; end
      4'd4:  begin a = 2'b10; b = 2'b01; imm = (op == OP_SW) ? 3'b001 : 3'b000; end
      4'd5:  begin req = 1; adr = 1; end
      4'd6:  begin req = 1; we = 1; adr = 1; ret = acc; end
      4'd7:  begin rw = 1; rs = 2'b01; ret = 1; end
      4'd8:  begin rw = 1; ret = 1; end
      4'd9:  begin a = 2'b10; aop = 2'b01; pcw = bt; ret = 1; end
      4'd10: begin a = 2'b01; b = 2'b10; pcw = 1; end
      4'd11: begin a = 2'b10; b = 2'b01; rs = 2'b10; pcw = 1; end
      4'd12: begin imm = 3'b011; rs = 2'b11; rw = 1; ret = 1; end
      4'd13: begin a = 2'b01; b = 2'b01; imm = 3'b011; end
      4'd14: begin a = 2'b01; b = 2'b10; end
      default: begin flt = 1; fc = cause; end
    endcase
    return {st, req, we, adr, irw, pcw, rw, a, b, aop, imm, rs, ret, flt, fc};
  endfunction

  task automatic push(input int unsigned inst, input logic [3:0] st, input logic [6:0] op,
                      input logic mr, input logic bt, input logic [1:0] cause);
    ent_t e;
    e.inst = inst; e.st = st; e.op = op; e.mr = mr; e.bt = bt; e.cause = cause;
    sb.push_back(e);
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    logic [24:0] exp;
    resetn = 1'b0;
    mem_ready = 1'b0;
    opcode = OP_LW;
    #1;
    exp = exp_vec(4'd0, OP_LW, 1'b0, 1'b0, 2'b00, 1'b1) & ~(25'b1 << 20);
    checks++;
    if (obs[0] !== exp) begin
      errors++; $display("FAIL reset_state: got %h required %h", obs[0], exp);
    end
    @(negedge clk);
    resetn = 1'b1;
    push(0, 4'd0, OP_LW, 1, 0, 0); push(0, 4'd1, OP_LW, 1, 0, 0);
    push(0, 4'd4, OP_LW, 1, 0, 0); push(0, 4'd5, OP_LW, 0, 0, 0);
    while (sb.size() != 0) begin
      ent_t e = sb.pop_front();
      opcode = e.op; mem_ready = e.mr; branch_taken = e.bt;
      #1;
      exp = exp_vec(e.st, e.op, e.bt, e.mr | !cfg_hs(e.inst), e.cause, cfg_trap(e.inst));
      checks++;
      if (obs[e.inst] !== exp) begin
        errors++; $display("FAIL reset_pre st=%0d: got %h required %h", e.st, obs[e.inst], exp);
      end
      @(negedge clk);
    end
    // still stalled in MEM_RD; reset lands mid-cycle
    #2;
    resetn = 1'b0;
    #1;
    exp = exp_vec(4'd0, OP_LW, 1'b0, 1'b0, 2'b00, 1'b1) & ~(25'b1 << 20);
    checks++;
    if (obs[0] !== exp) begin
      errors++; $display("FAIL reset_midwait: got %h required %h", obs[0], exp);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_load();
    logic [24:0] exp;
    int ret_seen = 0;
    apply_reset();
    push(0, 4'd0, OP_LW, 1, 0, 0); push(0, 4'd1, OP_LW, 1, 0, 0);
    push(0, 4'd4, OP_LW, 1, 0, 0); push(0, 4'd5, OP_LW, 1, 0, 0);
    push(0, 4'd7, OP_LW, 1, 0, 0); push(0, 4'd0, OP_LW, 0, 0, 0);
    while (sb.size() != 0) begin
      ent_t e = sb.pop_front();
      opcode = e.op; mem_ready = e.mr; branch_taken = e.bt;
      #1;
      exp = exp_vec(e.st, e.op, e.bt, e.mr | !cfg_hs(e.inst), e.cause, cfg_trap(e.inst));
      checks++;
      if (obs[e.inst] !== exp) begin
        errors++; $display("FAIL load st=%0d: got %h required %h", e.st, obs[e.inst], exp);
      end
      if (obs[e.inst][3] === 1'b1) ret_seen++;
      @(negedge clk);
    end
    checks++;
    if (ret_seen != 1) begin
      errors++; $display("FAIL load_retire_count: got %0d required 1", ret_seen);
    end
  endtask

  task automatic test_store_wait();
    logic [24:0] exp;
    apply_reset();
    push(0, 4'd0, OP_SW, 1, 0, 0); push(0, 4'd1, OP_SW, 1, 0, 0);
    push(0, 4'd4, OP_SW, 1, 0, 0);
    for (int i = 0; i < 3; i++) push(0, 4'd6, OP_SW, 0, 0, 0);
    push(0, 4'd6, OP_SW, 1, 0, 0); push(0, 4'd0, OP_SW, 0, 0, 0);
    while (sb.size() != 0) begin
      ent_t e = sb.pop_front();
      opcode = e.op; mem_ready = e.mr; branch_taken = e.bt;
      #1;
      exp = exp_vec(e.st, e.op, e.bt, e.mr | !cfg_hs(e.inst), e.cause, cfg_trap(e.inst));
      checks++;
      if (obs[e.inst] !== exp) begin
        errors++; $display("FAIL store_wait st=%0d: got %h required %h", e.st, obs[e.inst], exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    logic [24:0] exp;
    apply_reset();
    for (int t = 0; t < 2; t++) begin
      push(0, 4'd0, OP_BR, 1, t[0], 0); push(0, 4'd1, OP_BR, 1, t[0], 0);
      push(0, 4'd9, OP_BR, 1, t[0], 0);
    end
    push(0, 4'd0, OP_BR, 0, 0, 0);
    while (sb.size() != 0) begin
      ent_t e = sb.pop_front();
      opcode = e.op; mem_ready = e.mr; branch_taken = e.bt;
      #1;
      exp = exp_vec(e.st, e.op, e.bt, e.mr | !cfg_hs(e.inst), e.cause, cfg_trap(e.inst));
      checks++;
      if (obs[e.inst] !== exp) begin
        errors++; $display("FAIL branch st=%0d bt=%0d: got %h required %h", e.st, e.bt, obs[e.inst], exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_jalr();
    logic [24:0] exp;
    apply_reset();
    push(0, 4'd0, OP_JALR, 1, 0, 0); push(0, 4'd1, OP_JALR, 1, 0, 0);
    push(0, 4'd11, OP_JALR, 1, 0, 0); push(0, 4'd14, OP_JALR, 1, 0, 0);
    push(0, 4'd8, OP_JALR, 1, 0, 0); push(0, 4'd0, OP_JALR, 0, 0, 0);
    while (sb.size() != 0) begin
      ent_t e = sb.pop_front();
      opcode = e.op; mem_ready = e.mr; branch_taken = e.bt;
      #1;
      exp = exp_vec(e.st, e.op, e.bt, e.mr | !cfg_hs(e.inst), e.cause, cfg_trap(e.inst));
      checks++;
      if (obs[e.inst] !== exp) begin
        errors++; $display("FAIL jalr st=%0d: got %h required %h", e.st, obs[e.inst], exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [24:0] exp;
    apply_reset();
    push(0, 4'd0, OP_LUI, 1, 0, 0);   push(0, 4'd1, OP_LUI, 1, 0, 0);
    push(0, 4'd12, OP_LUI, 1, 0, 0);
    push(0, 4'd0, OP_AUIPC, 1, 0, 0); push(0, 4'd1, OP_AUIPC, 1, 0, 0);
    push(0, 4'd13, OP_AUIPC, 1, 0, 0); push(0, 4'd8, OP_AUIPC, 1, 0, 0);
    push(0, 4'd0, OP_JAL, 1, 0, 0);   push(0, 4'd1, OP_JAL, 1, 0, 0);
    push(0, 4'd10, OP_JAL, 1, 0, 0);  push(0, 4'd8, OP_JAL, 1, 0, 0);
    push(0, 4'd0, OP_R, 1, 0, 0);     push(0, 4'd1, OP_R, 1, 0, 0);
    push(0, 4'd2, OP_R, 1, 0, 0);     push(0, 4'd8, OP_R, 1, 0, 0);
    push(0, 4'd0, OP_I, 1, 0, 0);     push(0, 4'd1, OP_I, 1, 0, 0);
    push(0, 4'd3, OP_I, 1, 0, 0);     push(0, 4'd8, OP_I, 1, 0, 0);
    push(0, 4'd0, OP_I, 0, 0, 0);
    while (sb.size() != 0) begin
      ent_t e = sb.pop_front();
      opcode = e.op; mem_ready = e.mr; branch_taken = e.bt;
      #1;
      exp = exp_vec(e.st, e.op, e.bt, e.mr | !cfg_hs(e.inst), e.cause, cfg_trap(e.inst));
      checks++;
      if (obs[e.inst] !== exp) begin
        errors++; $display("FAIL back_to_back st=%0d op=%b: got %h required %h", e.st, e.op, obs[e.inst], exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    logic [24:0] exp;
    apply_reset();
    for (int i = 0; i < 4; i++) push(1, 4'd0, OP_LW, 0, 0, 0);
    push(1, 4'd15, OP_LW, 0, 0, 2'b10); push(1, 4'd15, OP_LW, 1, 0, 2'b10);
    while (sb.size() != 0) begin
      ent_t e = sb.pop_front();
      opcode = e.op; mem_ready = e.mr; branch_taken = e.bt;
      #1;
      exp = exp_vec(e.st, e.op, e.bt, e.mr | !cfg_hs(e.inst), e.cause, cfg_trap(e.inst));
      checks++;
      if (obs[e.inst] !== exp) begin
        errors++; $display("FAIL timeout st=%0d: got %h required %h", e.st, obs[e.inst], exp);
      end
      @(negedge clk);
    end
    // ready on the last allowed stall cycle wins; counter restarts per wait state
    apply_reset();
    for (int i = 0; i < 3; i++) push(1, 4'd0, OP_LW, 0, 0, 0);
    push(1, 4'd0, OP_LW, 1, 0, 0); push(1, 4'd1, OP_LW, 1, 0, 0);
    push(1, 4'd4, OP_LW, 1, 0, 0);
    for (int i = 0; i < 3; i++) push(1, 4'd5, OP_LW, 0, 0, 0);
    push(1, 4'd5, OP_LW, 1, 0, 0); push(1, 4'd7, OP_LW, 1, 0, 0);
    push(1, 4'd0, OP_LW, 1, 0, 0);
    while (sb.size() != 0) begin
      ent_t e = sb.pop_front();
      opcode = e.op; mem_ready = e.mr; branch_taken = e.bt;
      #1;
      exp = exp_vec(e.st, e.op, e.bt, e.mr | !cfg_hs(e.inst), e.cause, cfg_trap(e.inst));
      checks++;
      if (obs[e.inst] !== exp) begin
        errors++; $display("FAIL timeout_edge st=%0d: got %h required %h", e.st, obs[e.inst], exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    logic [24:0] exp;
    apply_reset();
    push(0, 4'd0, OP_BAD, 1, 0, 0); push(0, 4'd1, OP_BAD, 1, 0, 0);
    push(0, 4'd15, OP_BAD, 1, 0, 2'b01); push(0, 4'd15, OP_BAD, 1, 0, 2'b01);
    while (sb.size() != 0) begin
      ent_t e = sb.pop_front();
      opcode = e.op; mem_ready = e.mr; branch_taken = e.bt;
      #1;
      exp = exp_vec(e.st, e.op, e.bt, e.mr | !cfg_hs(e.inst), e.cause, cfg_trap(e.inst));
      checks++;
      if (obs[e.inst] !== exp) begin
        errors++; $display("FAIL illegal_trap st=%0d: got %h required %h", e.st, obs[e.inst], exp);
      end
      @(negedge clk);
    end
    apply_reset();
    push(2, 4'd0, OP_BAD, 1, 0, 0); push(2, 4'd1, OP_BAD, 1, 0, 0);
    push(2, 4'd0, OP_BAD, 0, 0, 0);
    while (sb.size() != 0) begin
      ent_t e = sb.pop_front();
      opcode = e.op; mem_ready = e.mr; branch_taken = e.bt;
      #1;
      exp = exp_vec(e.st, e.op, e.bt, e.mr | !cfg_hs(e.inst), e.cause, cfg_trap(e.inst));
      checks++;
      if (obs[e.inst] !== exp) begin
        errors++; $display("FAIL illegal_nop st=%0d: got %h required %h", e.st, obs[e.inst], exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_no_handshake();
    logic [24:0] exp;
    apply_reset();
    push(3, 4'd0, OP_LW, 0, 0, 0); push(3, 4'd1, OP_LW, 0, 0, 0);
    push(3, 4'd4, OP_LW, 0, 0, 0); push(3, 4'd5, OP_LW, 0, 0, 0);
    push(3, 4'd7, OP_LW, 0, 0, 0);
    push(3, 4'd0, OP_SW, 0, 0, 0); push(3, 4'd1, OP_SW, 0, 0, 0);
    push(3, 4'd4, OP_SW, 0, 0, 0); push(3, 4'd6, OP_SW, 0, 0, 0);
    push(3, 4'd0, OP_SW, 0, 0, 0);
    while (sb.size() != 0) begin
      ent_t e = sb.pop_front();
      opcode = e.op; mem_ready = e.mr; branch_taken = e.bt;
      #1;
      exp = exp_vec(e.st, e.op, e.bt, e.mr | !cfg_hs(e.inst), e.cause, cfg_trap(e.inst));
      checks++;
      if (obs[e.inst] !== exp) begin
        errors++; $display("FAIL no_handshake st=%0d: got %h required %h", e.st, obs[e.inst], exp);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_wait();
    test_branch();
    test_jalr();
    test_back_to_back();
    test_timeout();
    test_illegal();
    test_no_handshake();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
